// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit: single-outstanding instruction fetch with a prefetch buffer.
// Optional: FETCH_STATS_EN adds fetch_count.   Rev 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
`ifdef FETCH_STATS_EN
  output logic [31:0] fetch_count,
`endif
  output logic        fetch_fault
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   addr_q;
  logic          req_q;
  logic          kill_q;
  logic          fault_q;

  logic [31:0]   word_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic          w_misalign;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_after_pop;

  assign w_misalign        = |redirect_pc[1:0];
  assign w_flush           = redirect && (state_q != ST_FAULT);
  // A response is kept only if no kill is pending and no redirect lands on it.
  assign w_push            = (state_q == ST_WAIT) && imem_ack && !kill_q && !redirect;
  assign w_pop             = inst_valid && inst_ready && !w_flush;
  assign w_count_after_pop = count_q - CW'(w_pop);
  assign count_d           = count_q + CW'(w_push) - CW'(w_pop);

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = (count_q != '0);
  assign inst        = word_mem_q[rd_ptr_q];
  assign inst_pc     = pc_mem_q[rd_ptr_q];
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      kill_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (redirect && w_misalign) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
          end else if (w_count_after_pop < DEPTH_C) begin
            // Occupancy cannot grow while waiting, so room now means room at ack.
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            req_q  <= 1'b0;
            kill_q <= 1'b0;
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
          if (redirect && w_misalign) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else begin
            if (redirect) begin
              fetch_pc_q <= redirect_pc;
            end else if (imem_ack && !kill_q) begin
              fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (imem_ack) begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FAULT: begin
          if (imem_ack) begin
            req_q  <= 1'b0;
            kill_q <= 1'b0;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (w_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        word_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]   <= addr_q;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else if (inst_valid && inst_ready) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Rev 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_count2;
`endif

  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] inst2;
  logic [31:0] pc2;
  logic        fault2;
  logic        ready2 = 1'b1;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;

  int          ack_lat;
  int          wait_cnt = 0;
  logic        mem_en;
  logic        ack_force;
  logic        rec2;
  logic [31:0] pcs2[$];
  logic [31:0] words2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: word at address A is ~A; ack after ack_lat cycles of request.
  assign imem_rdata = ~imem_addr;
  assign imem_ack   = ack_force | (mem_en & imem_req & (wait_cnt >= ack_lat));

  always @(posedge clk) begin
    wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    if (rec2 && valid2 && ready2) begin
      pcs2.push_back(pc2);
      words2.push_back(inst2);
    end
  end

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
`ifdef FETCH_STATS_EN
    .fetch_count (fetch_count),
`endif
    .fetch_fault (fetch_fault)
  );

  fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (4)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_ack    (req2),
    .imem_rdata  (~addr2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .inst_valid  (valid2),
    .inst        (inst2),
    .inst_pc     (pc2),
    .inst_ready  (ready2),
`ifdef FETCH_STATS_EN
    .fetch_count (fetch_count2),
`endif
    .fetch_fault (fault2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  // Wait (bounded) for a head entry, check it, then let it transfer.
  task automatic expect_xfer(input logic [31:0] pc);
    int n = 0;
    while (!inst_valid && n < 40) begin
      tick();
      n++;
    end
    check("xfer_valid", {31'b0, inst_valid}, 32'd1);
    check("xfer_pc", inst_pc, pc);
    check("xfer_inst", inst, ~pc);
    tick();
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    ack_lat = 0; mem_en = 1'b1; ack_force = 1'b0; rec2 = 1'b0;
    tick(); tick(); tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Zero-wait streaming from reset
    reset = 1'b0; rec2 = 1'b1;
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid_lat1", {31'b0, inst_valid}, 32'd0);
    tick();
    check("first_valid_lat2", {31'b0, inst_valid}, 32'd1);
    expect_xfer(32'h0);
    expect_xfer(32'h4);
    expect_xfer(32'h8);

    // Back-pressure: buffer fills, request stops, head holds
    inst_ready = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", inst_pc, 32'hC);
      check("stall_inst", inst, ~32'hC);
    end
    check("stall_req", {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1; rec2 = 1'b0;
    expect_xfer(32'hC);
    expect_xfer(32'h10);
    expect_xfer(32'h14);

    // Redirect while the request to 0x0C is outstanding (3-cycle ack)
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    ack_lat = 2;
    expect_xfer(32'h0);
    expect_xfer(32'h4);
    expect_xfer(32'h8);
    wait_req();
    check("kill_addr", imem_addr, 32'hC);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("kill_req_hold", {31'b0, imem_req}, 32'd1);
    check("kill_addr_hold", imem_addr, 32'hC);
    check("kill_flush", {31'b0, inst_valid}, 32'd0);
    expect_xfer(32'h40);
    expect_xfer(32'h44);

    // Redirect coincident with a zero-wait ack
    ack_lat = 0;
    wait_req();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("coack_flush", {31'b0, inst_valid}, 32'd0);
    expect_xfer(32'h100);
    expect_xfer(32'h104);

    // Reset mid-request, then a stale ack before the new request
    ack_lat = 6;
    wait_req();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_en = 1'b0; ack_force = 1'b1;
    tick();
    ack_force = 1'b0; mem_en = 1'b1; ack_lat = 0;
    check("late_valid", {31'b0, inst_valid}, 32'd0);
    check("late_req", {31'b0, imem_req}, 32'd1);
    check("late_addr", imem_addr, 32'h0);
    expect_xfer(32'h0);
    expect_xfer(32'h4);

    // Misaligned redirect: sticky fault
    wait_req();
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    check("fault_set", {31'b0, fetch_fault}, 32'd1);
    check("fault_req", {31'b0, imem_req}, 32'd0);
    check("fault_valid", {31'b0, inst_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("fault_hold_req", {31'b0, imem_req}, 32'd0);
      check("fault_hold_valid", {31'b0, inst_valid}, 32'd0);
    end
    check("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("fault_clear", {31'b0, fetch_fault}, 32'd0);

    // Seven transfers then a redirect
    for (int i = 0; i < 7; i++) begin
      expect_xfer(32'(i * 4));
    end
    inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    tick();
`ifdef FETCH_STATS_EN
    check("fetch_count", fetch_count, 32'd7);
`endif
    inst_ready = 1'b1;
    expect_xfer(32'h200);

    // Wrap-around from RESET_PC = FFFFFFF8 (depth-4 instance)
    check("wrap_count", pcs2.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("wrap_pc", pcs2.size() > i ? pcs2[i] : 32'hDEAD_BEEF, 32'hFFFF_FFF8 + 32'(i * 4));
      check("wrap_inst", words2.size() > i ? words2[i] : 32'hDEAD_BEEF, ~(32'hFFFF_FFF8 + 32'(i * 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
